// File: rtl/fb_pattern_writer.sv
// fb_pattern_writer: walks one 1-bpp frame per start request and streams packed
// pixel words, with linear word addresses, into the display buffer RAM write
// port. It offers four patterns (solid, checker, diagonal, box) and a
// valid/ready handshake that supports back-pressure.
// Optional feature: define FB_PATTERN_WRITER_INVERT_EN to add an `invert` input.
// That input is captured at start. When it is set, every data word is complemented.
module fb_pattern_writer #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 480,
  parameter int WORD_W   = 16,
  parameter int ADDR_W   = 16,
  localparam int X_W     = $clog2(H_ACTIVE),
  localparam int Y_W     = $clog2(V_ACTIVE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [X_W-1:0]    box_x0,
  input  logic [X_W-1:0]    box_x1,
  input  logic [Y_W-1:0]    box_y0,
  input  logic [Y_W-1:0]    box_y1,
`ifdef FB_PATTERN_WRITER_INVERT_EN
  input  logic              invert,
`endif
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam int WPL  = H_ACTIVE / WORD_W;
  localparam int XW_W = (WPL > 1) ? $clog2(WPL) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_n;

  logic [XW_W-1:0]   xw_q, xw_n;
  logic [Y_W-1:0]    y_q, y_n;
  logic [ADDR_W-1:0] addr_n;
  logic [WORD_W-1:0] data_n;
  logic              en_n, busy_n, done_n;

  // Frame configuration, frozen at start so later input changes cannot
  // disturb a frame in flight.
  logic [1:0]        mode_q, mode_n;
  logic [X_W-1:0]    bx0_q, bx0_n, bx1_q, bx1_n;
  logic [Y_W-1:0]    by0_q, by0_n, by1_q, by1_n;
  logic              inv_q, inv_n;

  logic              hs;
  logic              last_word;

  // Builds one packed word. Bit i is the pixel at x = xw*WORD_W + i, so bit 0
  // is the leftmost pixel. The arithmetic is 32-bit. For the diagonal, only the
  // low four bits of x+y matter, so the result equals a sum taken at X_W+1 bits.
  function automatic logic [WORD_W-1:0] pattern_word(
    input logic [XW_W-1:0] xw,
    input logic [Y_W-1:0]  yy,
    input logic [1:0]      m,
    input logic [X_W-1:0]  x0,
    input logic [X_W-1:0]  x1,
    input logic [Y_W-1:0]  y0,
    input logic [Y_W-1:0]  y1,
    input logic            inv
  );
    logic [WORD_W-1:0] w;
    logic [31:0]       x32;
    logic [31:0]       y32;
    logic [31:0]       s32;
    logic              in_box;
    w   = '0;
    y32 = 32'(yy);
    for (int i = 0; i < WORD_W; i++) begin
      x32    = 32'(xw) * WORD_W + i;
      s32    = x32 + y32;
      // An inverted bound pair can never satisfy both comparisons, so the box is empty.
      in_box = (x32 >= 32'(x0)) && (x32 <= 32'(x1)) &&
               (y32 >= 32'(y0)) && (y32 <= 32'(y1));
      case (m)
        2'd0:    w[i] = 1'b1;
        2'd1:    w[i] = x32[3] ^ y32[3];
        2'd2:    w[i] = ((s32 & 32'd15) < 32'd8);
        default: w[i] = ~in_box;
      endcase
    end
    if (inv) w = ~w;
    return w;
  endfunction

  assign hs        = wr_en && wr_ready;
  assign last_word = (xw_q == XW_W'(WPL - 1)) && (y_q == Y_W'(V_ACTIVE - 1));

  // FSM state register; reset always lands in IDLE, even if start is high on the same edge.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_n;
  end

  // Next state, next counters and the next (registered) output values.
  always_comb begin
    state_n = state_q;
    xw_n    = xw_q;
    y_n     = y_q;
    addr_n  = wr_addr;
    en_n    = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    mode_n  = mode_q;
    bx0_n   = bx0_q;
    bx1_n   = bx1_q;
    by0_n   = by0_q;
    by1_n   = by1_q;
    inv_n   = inv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n = S_WRITE;
          xw_n    = '0;
          y_n     = '0;
          addr_n  = '0;
          en_n    = 1'b1;
          busy_n  = 1'b1;
          mode_n  = mode;
          bx0_n   = box_x0;
          bx1_n   = box_x1;
          by0_n   = box_y0;
          by1_n   = box_y1;
`ifdef FB_PATTERN_WRITER_INVERT_EN
          inv_n   = invert;
`else
          inv_n   = 1'b0;
`endif
        end
      end
      S_WRITE: begin
        en_n   = 1'b1;
        busy_n = 1'b1;
        if (hs) begin
          if (last_word) begin
            state_n = S_DONE;
            en_n    = 1'b0;
            done_n  = 1'b1;
            addr_n  = '0;
          end else begin
            addr_n = wr_addr + ADDR_W'(1);
            if (xw_q == XW_W'(WPL - 1)) begin
              xw_n = '0;
              y_n  = y_q + Y_W'(1);
            end else begin
              xw_n = xw_q + XW_W'(1);
            end
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    // The word is recomputed from the held counters, so it stays stable while stalled.
    data_n = en_n ? pattern_word(xw_n, y_n, mode_n, bx0_n, bx1_n, by0_n, by1_n, inv_n)
                  : '0;
  end

  // Counter, configuration and output registers; all outputs leave from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      xw_q    <= '0;
      y_q     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      mode_q  <= '0;
      bx0_q   <= '0;
      bx1_q   <= '0;
      by0_q   <= '0;
      by1_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      xw_q    <= xw_n;
      y_q     <= y_n;
      wr_en   <= en_n;
      wr_addr <= addr_n;
      wr_data <= data_n;
      busy    <= busy_n;
      done    <= done_n;
      mode_q  <= mode_n;
      bx0_q   <= bx0_n;
      bx1_q   <= bx1_n;
      by0_q   <= by0_n;
      by1_q   <= by1_n;
      inv_q   <= inv_n;
    end
  end

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Testbench for fb_pattern_writer: a table of known words, hand-written
// sequences for reset, back-pressure and start handling, and random frames
// checked against an address-based pixel model.
module tb_fb_pattern_writer;

  localparam int H   = 800;
  localparam int V   = 480;
  localparam int WW  = 16;
  localparam int AW  = 16;
  localparam int WPL = H / WW;
  localparam int F   = H * V / WW;
  localparam int XW  = $clog2(H);
  localparam int YW  = $clog2(V);

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    mode;
  logic [XW-1:0] box_x0, box_x1;
  logic [YW-1:0] box_y0, box_y1;
  logic          wr_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [WW-1:0] wr_data;
  logic          busy;
  logic          done;
`ifdef FB_PATTERN_WRITER_INVERT_EN
  logic          invert;
`endif

  always #5 clk = ~clk;

  fb_pattern_writer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .WORD_W(WW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .box_x0(box_x0), .box_x1(box_x1), .box_y0(box_y0), .box_y1(box_y1),
`ifdef FB_PATTERN_WRITER_INVERT_EN
    .invert(invert),
`endif
    .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  int errors = 0;
  int checks = 0;

  // Configuration of the frame the model expects.
  int c_mode, c_x0, c_x1, c_y0, c_y1;
  bit c_inv;

  int exp_addr, nwords, cnt5, cap_addr;
  bit cap_ok;
  logic [WW-1:0] cap_data;
  bit prev_stall;
  logic [AW-1:0] prev_addr;
  logic [WW-1:0] prev_data;

  typedef struct {
    int mode; int x0; int x1; int y0; int y1; bit inv;
    int addr; logic [WW-1:0] exp;
  } vec_t;
  vec_t vecs[12];
  int   n_vec;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference pixel model: derives (x, y) from the linear address.
  function automatic logic [WW-1:0] model_word(input int a);
    int y, xb, x;
    bit p;
    logic [WW-1:0] w;
    y  = a / WPL;
    xb = (a % WPL) * WW;
    for (int i = 0; i < WW; i++) begin
      x = xb + i;
      case (c_mode)
        0:       p = 1'b1;
        1:       p = ((x / 8) % 2) != ((y / 8) % 2);
        2:       p = ((x + y) % 16) < 8;
        default: p = !(x >= c_x0 && x <= c_x1 && y >= c_y0 && y <= c_y1);
      endcase
      w[i] = p;
    end
    if (c_inv) w = ~w;
    return w;
  endfunction

  // Called at the falling edge: checks the word handshaked at the next rising edge.
  task automatic sample();
    if (prev_stall) begin
      chk("hold_en", wr_en, 1);
      chk("hold_addr", wr_addr, prev_addr);
      chk("hold_data", wr_data, prev_data);
    end
    if (busy && !done) chk("valid_mid", wr_en, 1);
    if (wr_en && wr_ready) begin
      chk("addr", wr_addr, exp_addr[AW-1:0]);
      chk("data", wr_data, model_word(exp_addr));
      if (exp_addr == cap_addr) begin
        cap_data = wr_data;
        cap_ok   = 1'b1;
      end
      exp_addr++;
      nwords++;
    end
    if (wr_en && wr_addr == 5) cnt5++;
    prev_stall = wr_en && !wr_ready;
    prev_addr  = wr_addr;
    prev_data  = wr_data;
  endtask

  task automatic start_frame(input int m, input int x0, input int x1,
                             input int y0, input int y1, input bit inv);
    mode   = m[1:0];
    box_x0 = x0[XW-1:0];
    box_x1 = x1[XW-1:0];
    box_y0 = y0[YW-1:0];
    box_y1 = y1[YW-1:0];
    c_mode = m; c_x0 = x0; c_x1 = x1; c_y0 = y0; c_y1 = y1;
`ifdef FB_PATTERN_WRITER_INVERT_EN
    invert = inv;
    c_inv  = inv;
`else
    c_inv  = 1'b0;
`endif
    start = 1'b1;
  endtask

  // Runs a frame whose start is already driven. It stops on done, on a reset
  // abort, or when the cycle budget runs out. Cycle k counts from the start edge N.
  task automatic run_frame(input bit rnd_ready, input int stall_at, input int abort_at,
                           input bit start_in_done, output int done_k);
    int k;
    int stalls;
    bit fin;
    exp_addr = 0; nwords = 0; cnt5 = 0; cap_ok = 1'b0; prev_stall = 1'b0;
    stalls = 3; done_k = -1; wr_ready = 1'b1; fin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    k = 1;
    chk("lat_en", wr_en, 1);
    chk("lat_addr", wr_addr, 0);
    chk("lat_busy", busy, 1);
    while (!fin && k < 3 * F + 100) begin
      if (done) begin
        done_k = k;
        start  = start_in_done;
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_pulse", done, 0);
        chk("busy_after", busy, 0);
        chk("en_after", wr_en, 0);
        @(posedge clk); #1;
        chk("idle_stays", busy, 0);
        fin = 1'b1;
      end else if (cap_ok || (abort_at >= 0 && wr_en && wr_addr == abort_at[AW-1:0])) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_en", wr_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", wr_addr, 0);
        fin = 1'b1;
      end else begin
        wr_ready = rnd_ready ? ($urandom_range(7) != 0) : 1'b1;
        if (stall_at >= 0 && wr_en && wr_addr == stall_at[AW-1:0] && stalls > 0) begin
          wr_ready = 1'b0;
          stalls--;
        end
        if (wr_en && (k % 997) == 500) begin
          start = 1'b1;
          mode  = ~mode;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        sample();
        @(posedge clk); #1;
        k++;
      end
    end
    start    = 1'b0;
    wr_ready = 1'b1;
    if (!fin) chk("frame_timeout", 0, 1);
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dk;
    reset = 1'b1; start = 1'b0; mode = 2'd0; wr_ready = 1'b0;
    box_x0 = '0; box_x1 = '0; box_y0 = '0; box_y1 = '0;
`ifdef FB_PATTERN_WRITER_INVERT_EN
    invert = 1'b0;
`endif
    cap_addr = -1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    // Reset and start on the same edge: reset wins.
    start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_en", wr_en, 0);
    @(posedge clk); #1;
    chk("rst_start_idle", busy, 0);

    // Solid frame with a 3-cycle stall on addr 5, mid-frame start pulses and a start in DONE.
    start_frame(0, 0, 0, 0, 0, 1'b0);
    run_frame(1'b0, 5, -1, 1'b1, dk);
    chk("solid_words", nwords, F);
    chk("solid_done_cycle", dk, F + 4);
    chk("solid_addr5_cycles", cnt5, 4);

    // Known words.
    n_vec = 0;
    vecs[n_vec++] = '{1, 0, 0, 0, 0, 1'b0, 0,    16'hFF00};
    vecs[n_vec++] = '{1, 0, 0, 0, 0, 1'b0, 50,   16'hFF00};
    vecs[n_vec++] = '{1, 0, 0, 0, 0, 1'b0, 400,  16'h00FF};
    vecs[n_vec++] = '{2, 0, 0, 0, 0, 1'b0, 0,    16'h00FF};
    vecs[n_vec++] = '{3, 150, 250, 150, 250, 1'b0, 7500, 16'hFFFF};
    vecs[n_vec++] = '{3, 150, 250, 150, 250, 1'b0, 7509, 16'h003F};
    vecs[n_vec++] = '{3, 150, 250, 150, 250, 1'b0, 7515, 16'hF800};
    vecs[n_vec++] = '{3, 250, 150, 0, 400, 1'b0, 9,    16'hFFFF};
`ifdef FB_PATTERN_WRITER_INVERT_EN
    vecs[n_vec++] = '{0, 0, 0, 0, 0, 1'b1, 0,    16'h0000};
    vecs[n_vec++] = '{0, 0, 0, 0, 0, 1'b1, 123,  16'h0000};
    vecs[n_vec++] = '{1, 0, 0, 0, 0, 1'b1, 0,    16'h00FF};
`endif
    for (int v = 0; v < n_vec; v++) begin
      start_frame(vecs[v].mode, vecs[v].x0, vecs[v].x1, vecs[v].y0, vecs[v].y1, vecs[v].inv);
      cap_addr = vecs[v].addr;
      run_frame(1'b0, -1, -1, 1'b0, dk);
      cap_addr = -1;
      chk($sformatf("vec%0d_seen", v), cap_ok, 1);
      chk($sformatf("vec%0d_data", v), cap_data, vecs[v].exp);
    end

    // Reset while addr 100 is presented, then restart from addr 0.
    start_frame(1, 0, 0, 0, 0, 1'b0);
    run_frame(1'b0, -1, 100, 1'b0, dk);
    chk("abort_words", nwords, 100);
    start_frame(2, 0, 0, 0, 0, 1'b0);
    cap_addr = 30;
    run_frame(1'b1, -1, -1, 1'b0, dk);
    cap_addr = -1;
    chk("restart_seen", cap_ok, 1);

    // Random partial frames, then one random full frame, all with random back-pressure.
    for (int r = 0; r < 4; r++) begin
      start_frame($urandom_range(3), $urandom_range(H - 1), $urandom_range(H - 1),
                  $urandom_range(V - 1), $urandom_range(V - 1), 1'($urandom_range(1)));
      cap_addr = (r < 3) ? $urandom_range(1500) : -1;
      run_frame(1'b1, -1, -1, 1'b0, dk);
      if (r < 3) begin
        chk("rand_part_seen", cap_ok, 1);
      end else begin
        chk("rand_full_words", nwords, F);
        chk("rand_full_done", dk >= F + 1, 1);
      end
      cap_addr = -1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fb_pattern_writer.md
# fb_pattern_writer

Parametrised frame-buffer pattern writer: on a start request it walks one full 1-bpp frame and streams packed pixel words with linear addresses into the display buffer RAM write port. It generalises our fixed 800x480 box generator with configurable geometry and word width, four selectable patterns, a valid/ready write handshake with back-pressure, and start/busy/done control. It sits between the control logic and the buffer RAM that the VGA scan-out reads.

## Interface

- `H_ACTIVE`, default 800: active pixels per line. Must be a multiple of `WORD_W`.
- `V_ACTIVE`, default 480: active lines per frame.
- `WORD_W`, default 16: pixels per RAM word.
- `ADDR_W`, default 16: RAM address width. Must satisfy `2^ADDR_W >= H_ACTIVE*V_ACTIVE/WORD_W`.

Derived values:
- `WPL = H_ACTIVE/WORD_W`: words per line.
- `X_W = $clog2(H_ACTIVE)`.
- `Y_W = $clog2(V_ACTIVE)`.

Ports (synchronous, active-high reset):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a frame; sampled only in IDLE.
- `mode` in 2: pattern select; captured at start.
- `box_x0`, `box_x1` in X_W: box column bounds, inclusive; captured at start.
- `box_y0`, `box_y1` in Y_W: box row bounds, inclusive; captured at start.
- `wr_ready` in 1: RAM side accepts the current word.
- `wr_en` out 1: word valid.
- `wr_addr` out ADDR_W: linear word address.
- `wr_data` out WORD_W: packed pixels.
- `busy` out 1: frame in progress.
- `done` out 1: single-cycle frame-complete pulse.

## Operation

- FSM states:
  - IDLE: outputs low. `start`=1 → latch `mode` and the box bounds, clear counters, go to WRITE.
  - WRITE: `wr_en`=1. A handshake occurs on a rising edge with `wr_en && wr_ready`. On handshake, advance the word counter `xw` (0..WPL-1); on wrap, clear `xw` and increment `y` (0..V_ACTIVE-1). A handshake on the last word (`xw=WPL-1`, `y=V_ACTIVE-1`) goes to DONE.
  - DONE: `done`=1 for one cycle, `wr_en`=0, then go to IDLE.
- `wr_addr = y*WPL + xw`, truncated to ADDR_W. Addresses run 0..H_ACTIVE*V_ACTIVE/WORD_W-1 in order, with no gaps and no repeats.
- Packing: `wr_data[i]` is the pixel at `x = xw*WORD_W + i`, where bit 0 is the leftmost pixel.
- Pixel function p(x,y):
  - mode 0, solid: 1.
  - mode 1, checker: `x[3] ^ y[3]`.
  - mode 2, diagonal: `((x+y) mod 16) < 8`. The sum is computed at X_W+1 bits.
  - mode 3, box: 0 when `box_x0<=x<=box_x1 && box_y0<=y<=box_y1`, else 1. Inverted bounds (x0>x1 or y0>y1) give an empty box, i.e. all 1.
- `start` is ignored while `busy`=1. Input changes after capture have no effect on the frame in flight.
- `reset` in any state: return to IDLE on the next edge. No further words are written, and a partial frame is abandoned.

## Timing

- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0. Counters and latched config are 0.
- All outputs are registered.
- `start` sampled high at edge N:
  - `wr_en`=1, `wr_addr`=0 and valid data from cycle N+1.
  - `busy`=1 from cycle N+1 through the DONE cycle inclusive.
- Throughput: one word per cycle while `wr_ready`=1, with no bubbles between words.
- `wr_ready`=0: `wr_addr`/`wr_data` hold stable and `wr_en` stays 1. Valid never drops mid-frame.
- With `wr_ready` held at 1, the last word is presented at cycle N+F, where F = total words. `done` is high at cycle N+F+1 and `busy` is low at N+F+2.
- `start`=1 during the DONE cycle is ignored. A new frame can begin at the earliest with `start` sampled in IDLE at N+F+2.
- `reset` and `start` asserted on the same edge: reset wins and the FSM stays in IDLE.

## Configuration

- Macro: `FB_PATTERN_WRITER_INVERT_EN`.
- Defined:
  - Adds input `invert` (1 bit), captured at start like `mode`.
  - When captured high, every `wr_data` word is the bitwise complement of the pattern.
  - Addresses and timing are unchanged.
- Undefined: the `invert` port is absent and data is never inverted.

## Test plan

Default parameters unless stated; F = 24000.

- **Solid:** mode 0, `wr_ready`=1, `start` at edge N → 24000 writes, addr 0..23999, every data word 16'hFFFF, `done` pulse at N+24001, `busy` low at N+24002.
- **Checker:** mode 1 → addr 0 = 16'hFF00, addr 400 (y=8, xw=0) = 16'h00FF, addr 50 (y=1) = 16'hFF00.
- **Diagonal and box:**
  - Mode 2 → addr 0 = 16'h00FF.
  - Mode 3 with box 150..250 × 150..250 → addr 7509 (y=150, xw=9) = 16'h003F, addr 7500 = 16'hFFFF, addr 7515 (x 240..255) = 16'hF800.
- **Back-pressure:** `wr_ready`=0 for 3 cycles while addr 5 is presented → addr 5 and its data held for 4 cycles, then addr 6 follows. No word is skipped or duplicated, and `done` is delayed by 3 cycles.
- **Reset and ignored start:**
  - `reset` while addr 100 is presented → next cycle `wr_en`=0 and `busy`=0.
  - A following `start` restarts the frame from addr 0.
  - `start` pulses mid-frame have no effect.
- **Invert (macro defined):** mode 0 with `invert`=1 → all words 16'h0000. Mode 1 with `invert`=1 → addr 0 = 16'h00FF.
